// File: rtl/strip_placement_if.sv
// strip_placement_if
// Bundles the request, response, control and pipeline-side signals of the
// strip placement controller.
//   req_*   : placement request (valid/ready), req_width is the program width
//   resp_*  : placement result (valid/ready), held until accepted
//   clr     : clear table and window base (only acted on while idle)
//   busy    : controller is not idle
//   mp_*    : candidate window to the pipeline and its returned result
// Modports:
//   slave  : the controller's view
//   master : the environment's view (requester, responder and pipeline)
//
// Handshake rule for both req and resp: a transfer happens on a rising clock
// edge where valid and ready are both high; a source holds valid and its
// payload stable until that edge.
interface strip_placement_if;
    logic       req_valid;
    logic       req_ready;
    logic [4:0] req_width;

    logic       resp_valid;
    logic       resp_ready;
    logic [3:0] resp_strip_id;
    logic [7:0] resp_width;
    logic       resp_fail;
    logic [1:0] resp_retries;

    logic       clr;
    logic       busy;

    logic [3:0] mp_strip_id_1;
    logic [3:0] mp_strip_id_2;
    logic [3:0] mp_strip_id_3;
    logic [7:0] mp_occupied_width_1;
    logic [7:0] mp_occupied_width_2;
    logic [7:0] mp_occupied_width_3;
    logic [4:0] mp_width_in;
    logic [3:0] mp_min_strip_id;
    logic [7:0] mp_new_width;
    logic       mp_strike_flag;

    modport slave (
        input  req_valid, req_width, resp_ready, clr,
               mp_min_strip_id, mp_new_width, mp_strike_flag,
        output req_ready, resp_valid, resp_strip_id, resp_width, resp_fail,
               resp_retries, busy,
               mp_strip_id_1, mp_strip_id_2, mp_strip_id_3,
               mp_occupied_width_1, mp_occupied_width_2, mp_occupied_width_3,
               mp_width_in
    );

    modport master (
        output req_valid, req_width, resp_ready, clr,
               mp_min_strip_id, mp_new_width, mp_strike_flag,
        input  req_ready, resp_valid, resp_strip_id, resp_width, resp_fail,
               resp_retries, busy,
               mp_strip_id_1, mp_strip_id_2, mp_strip_id_3,
               mp_occupied_width_1, mp_occupied_width_2, mp_occupied_width_3,
               mp_width_in
    );
endinterface

// File: rtl/strip_placement_ctrl.sv
// strip_placement_ctrl
// Sequences one placement request at a time through the min-strip / strike
// pipeline. Keeps the occupancy table, presents a window of three strips
// starting at base, and commits the pipeline's result. A strike moves the
// window on by three strips and re-issues, up to MAX_RETRY times.
// Ports:
//   clk          : clock, rising edge
//   rst          : asynchronous active-high reset
//   bus          : strip_placement_if.slave (request, response, clr, busy, mp_*)
//   dbg_state_o  : current FSM state, for observation only
module strip_placement_ctrl #(
    parameter int STRIP_CNT = 8,   // 3..16
    parameter int MAX_RETRY = 2    // 0..3
) (
    input  logic              clk,
    input  logic              rst,
    strip_placement_if.slave  bus,
    output logic [2:0]        dbg_state_o
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_COMMIT = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    localparam logic [4:0] CNT  = 5'(STRIP_CNT);
    localparam logic [1:0] MAXR = 2'(MAX_RETRY);

    state_t     state_q, state_d;
    // Sized for the widest legal table so a 4-bit id always indexes it; entries
    // at or above STRIP_CNT are never written and stay zero.
    logic [7:0] table_q [16];
    logic [7:0] table_d [16];
    logic [3:0] base_q, base_d;
    logic [1:0] retry_q, retry_d;
    logic [4:0] width_q, width_d;
    logic [3:0] mp_id_q [3];
    logic [3:0] mp_id_d [3];
    logic [7:0] mp_w_q [3];
    logic [7:0] mp_w_d [3];
    logic [3:0] resp_id_q, resp_id_d;
    logic [7:0] resp_w_q, resp_w_d;
    logic       resp_fail_q, resp_fail_d;
    logic [1:0] resp_retries_q, resp_retries_d;

    logic [3:0] next_base;
    logic [3:0] win_base;
    logic [3:0] cand;
    logic       load_mp;

    // base < STRIP_CNT and the offset is at most 3 <= STRIP_CNT, so one
    // conditional subtract is a full modulo.
    function automatic logic [3:0] wrap(input logic [4:0] s);
        wrap = (s >= CNT) ? 4'(s - CNT) : s[3:0];
    endfunction

    assign next_base = wrap({1'b0, base_q} + 5'd3);

    always_comb begin
        state_d        = state_q;
        table_d        = table_q;
        base_d         = base_q;
        retry_d        = retry_q;
        width_d        = width_q;
        mp_id_d        = mp_id_q;
        mp_w_d         = mp_w_q;
        resp_id_d      = resp_id_q;
        resp_w_d       = resp_w_q;
        resp_fail_d    = resp_fail_q;
        resp_retries_d = resp_retries_q;
        win_base       = base_q;
        load_mp        = 1'b0;
        cand           = '0;

        case (state_q)
            S_IDLE: begin
                // A request takes priority over a simultaneous clr.
                if (bus.req_valid) begin
                    width_d = bus.req_width;
                    retry_d = '0;
                    load_mp = 1'b1;
                    state_d = S_ISSUE;
                end else if (bus.clr) begin
                    table_d = '{default: '0};
                    base_d  = '0;
                end
            end
            S_ISSUE:  state_d = S_WAIT;
            S_WAIT:   state_d = S_COMMIT;
            S_COMMIT: begin
                resp_id_d      = bus.mp_min_strip_id;
                resp_w_d       = bus.mp_new_width;
                resp_retries_d = retry_q;
                if (!bus.mp_strike_flag && ({1'b0, bus.mp_min_strip_id} < CNT)) begin
                    table_d[bus.mp_min_strip_id] = bus.mp_new_width;
                    resp_fail_d = 1'b0;
                    state_d     = S_RESP;
                end else if (bus.mp_strike_flag && (retry_q < MAXR)) begin
                    base_d   = next_base;
                    retry_d  = retry_q + 2'd1;
                    win_base = next_base;
                    load_mp  = 1'b1;
                    state_d  = S_ISSUE;
                end else begin
                    // Failed placement: resp_width carries the pipeline's
                    // returned width unchanged; nothing is written.
                    if (bus.mp_strike_flag) begin
                        base_d = next_base;
                    end
                    resp_fail_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Window reload reads the table as it stood before this edge, which
        // on a retry is unchanged because a strike never writes.
        if (load_mp) begin
            for (int k = 0; k < 3; k++) begin
                cand       = wrap({1'b0, win_base} + 5'(k));
                mp_id_d[k] = cand;
                mp_w_d[k]  = table_q[cand];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            table_q        <= '{default: '0};
            base_q         <= '0;
            retry_q        <= '0;
            width_q        <= '0;
            mp_id_q        <= '{default: '0};
            mp_w_q         <= '{default: '0};
            resp_id_q      <= '0;
            resp_w_q       <= '0;
            resp_fail_q    <= 1'b0;
            resp_retries_q <= '0;
        end else begin
            state_q        <= state_d;
            table_q        <= table_d;
            base_q         <= base_d;
            retry_q        <= retry_d;
            width_q        <= width_d;
            mp_id_q        <= mp_id_d;
            mp_w_q         <= mp_w_d;
            resp_id_q      <= resp_id_d;
            resp_w_q       <= resp_w_d;
            resp_fail_q    <= resp_fail_d;
            resp_retries_q <= resp_retries_d;
        end
    end

    assign bus.req_ready           = (state_q == S_IDLE);
    assign bus.busy                = (state_q != S_IDLE);
    assign bus.resp_valid          = (state_q == S_RESP);
    assign bus.resp_strip_id       = resp_id_q;
    assign bus.resp_width          = resp_w_q;
    assign bus.resp_fail           = resp_fail_q;
    assign bus.resp_retries        = resp_retries_q;
    assign bus.mp_strip_id_1       = mp_id_q[0];
    assign bus.mp_strip_id_2       = mp_id_q[1];
    assign bus.mp_strip_id_3       = mp_id_q[2];
    assign bus.mp_occupied_width_1 = mp_w_q[0];
    assign bus.mp_occupied_width_2 = mp_w_q[1];
    assign bus.mp_occupied_width_3 = mp_w_q[2];
    assign bus.mp_width_in         = width_q;
    assign dbg_state_o             = state_q;
endmodule
